// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined adder/subtractor built on two-level carry lookahead,
// with valid/ready handshaking on both the input and output sides.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG = WIDTH / GROUP;
  localparam int unsigned LW = 64;

  // Sum-of-products carry into position j: OR_k<j (g[k] & p[k+1..j-1]) | (c & p[0..j-1]).
  function automatic logic lookahead(input logic [LW-1:0] pp, input logic [LW-1:0] gg,
                                     input logic c, input int unsigned j);
    logic t;
    logic prop;
    t = 1'b0;
    for (int unsigned k = 0; k < LW; k++) begin
      if (k < j) begin
        prop = 1'b1;
        for (int unsigned m = 0; m < LW; m++) begin
          if (m > k && m < j) prop = prop & pp[m];
        end
        t = t | (gg[k] & prop);
      end
    end
    prop = 1'b1;
    for (int unsigned m = 0; m < LW; m++) begin
      if (m < j) prop = prop & pp[m];
    end
    return t | (c & prop);
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;
  logic             c0_c;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic             s1_c0;

  logic [NG:0]      gc_c;
  logic [WIDTH-1:0] c_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             zero_c;
  logic             s2_adv;

  // Subtraction folds into addition of ~b with an inverted carry-in.
  assign b_eff = sub ? ~b : b;
  assign c0_c  = sub ? ~cin : cin;
  assign p_c   = a ^ b_eff;
  assign g_c   = a & b_eff;

  // First level: group propagate/generate per GROUP-bit slice.
  always_comb begin
    gp_c = '0;
    gg_c = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      gp_c[j] = &p_c[j*GROUP +: GROUP];
      gg_c[j] = lookahead(LW'(p_c[j*GROUP +: GROUP]), LW'(g_c[j*GROUP +: GROUP]), 1'b0, GROUP);
    end
  end

  // Second level: group carries across groups, then bit carries inside each group.
  always_comb begin
    gc_c = '0;
    c_c  = '0;
    for (int unsigned j = 0; j <= NG; j++) begin
      gc_c[j] = lookahead(LW'(s1_gp), LW'(s1_gg), s1_c0, j);
    end
    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        c_c[j*GROUP + i] = lookahead(LW'(s1_p[j*GROUP +: GROUP]), LW'(s1_g[j*GROUP +: GROUP]),
                                     gc_c[j], i);
      end
    end
  end

  assign sum_c  = s1_p ^ c_c;
  assign cout_c = gc_c[NG];
  assign ovf_c  = c_c[WIDTH-1] ^ gc_c[NG];
  assign zero_c = ~|sum_c;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Stage valids and the result register; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
        ovf  <= ovf_c;
        zero <= zero_c;
      end
    end
  end

  // S1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_p  <= p_c;
      s1_g  <= g_c;
      s1_gp <= gp_c;
      s1_gg <= gg_c;
      s1_c0 <= c0_c;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vector table, handshake
// corner sequences and a long randomised run against an arithmetic model.
module tb_cla_pipe_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q[$];
  res_t pend;
  vec_t tbl[10];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    logic [W-1:0] ye;
    logic         ce;
    logic [W:0]   r;
    res_t         o;
    ye = s ? ~y : y;
    ce = s ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, ye} + (W+1)'(ce);
    o.sum  = r[W-1:0];
    o.cout = r[W];
    o.ovf  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    o.zero = (r[W-1:0] == '0);
    return o;
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W-1);
      3:       return ~(W'(1) << (W-1));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic res_t cur();
    return {sum, cout, ovf, zero};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = s;
    pend     = model(x, y, ci, s);
  endtask

  // Called at a falling edge: sample handshakes, score transfers, advance one cycle.
  task automatic tick(output bit acc, output bit popped);
    res_t e;
    #1;
    acc    = in_valid && in_ready && !rst;
    popped = out_valid && out_ready && !rst;
    if (popped) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got sum=%h with empty scoreboard, required none", sum);
      end else begin
        e = q.pop_front();
        check("result{sum,cout,ovf,zero}", 64'(cur()), 64'(e));
      end
    end
    if (acc) q.push_back(pend);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc, pop;
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      tick(acc, pop);
      n++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic latency_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic s);
    bit acc, pop;
    int n;
    out_ready = 1'b1;
    drive(1'b1, x, y, ci, s);
    tick(acc, pop);
    check({name, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick(acc, pop);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd2);
    drain();
  endtask

  initial begin
    bit   acc, pop, stall, seen;
    int   k, sent, cyc;
    res_t snap;
    logic [W-1:0] bx[3];
    logic [W-1:0] by[3];

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFD, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{16'h1234, 16'h1111, 1'b1, 1'b0, '{16'h2346, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
    tbl[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
    tbl[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    tbl[9] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);

    // Reset for two cycles with an input offered; it must be dropped.
    tick(acc, pop);
    tick(acc, pop);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'(cur()), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick(acc, pop);
    tick(acc, pop);
    check("rst_drop_input", 64'(out_valid), 64'd0);

    latency_check("lat", 16'hFFFF, 16'h0001, 1'b0, 1'b0);

    // Back-to-back directed vectors; full throughput after the fill.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      pend = tbl[i].exp;
      tick(acc, pop);
      check("table_accept", 64'(acc), 64'd1);
      if (i >= 2) check("table_throughput", 64'(pop), 64'd1);
    end
    drain();

    // Backpressure: only two fit, outputs hold, then a shift with no bubble.
    for (int i = 0; i < 3; i++) begin
      bx[i] = rv();
      by[i] = rv();
    end
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, bx[k], by[k], 1'b0, 1'b0);
      tick(acc, pop);
      if (acc) k++;
    end
    check("bp_accepted", 64'(k), 64'd2);
    drive(1'b1, bx[2], by[2], 1'b0, 1'b0);
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    snap = cur();
    tick(acc, pop);
    check("bp_ignored", 64'(acc), 64'd0);
    tick(acc, pop);
    check("bp_hold", 64'(cur()), 64'(snap));
    out_ready = 1'b1;
    tick(acc, pop);
    check("bp_same_cycle", 64'({acc, pop}), 64'b11);
    drain();

    // Reset mid-flight discards both in-flight results.
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
    tick(acc, pop);
    drive(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b0);
    tick(acc, pop);
    check("mid_rst_filled", 64'(q.size()), 64'd2);
    rst = 1'b1;
    in_valid = 1'b0;
    tick(acc, pop);
    q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen = 1'b1;
      tick(acc, pop);
    end
    check("mid_rst_flush", 64'(seen), 64'd0);
    latency_check("post_rst", 16'h0005, 16'h0007, 1'b1, 1'b1);

    // Randomised traffic with random stalls on both sides.
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 10000 && $urandom_range(0, 3) != 0)
        drive(1'b1, rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        in_valid = 1'b0;
      stall = out_valid && !out_ready;
      snap  = cur();
      tick(acc, pop);
      if (acc) sent++;
      if (stall) check("rand_hold", 64'({out_valid, cur()}), 64'({1'b1, snap}));
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd10000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
